// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Decodes ALUOp/funct and executes the operation with a registered result.
//   Single-cycle ops complete one cycle after accept; multiply runs as an
//   iterative shift-add over WIDTH cycles and returns the low WIDTH bits.
//
//   state | meaning
//   IDLE  | no result pending, ready for a new op
//   MUL   | shift-add multiply in progress, inputs not accepted
//   DONE  | result presented on out_valid, held until out_ready
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (alu_op, funct, a, b)
//   out_valid/out_ready result handshake (result, zero, alu_ctrl)
//   busy                unit is not idle
module alu_exec_unit #(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [3:0]       alu_ctrl,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] C_AND  = 4'b0000;
   localparam logic [3:0] C_OR   = 4'b0001;
   localparam logic [3:0] C_ADD  = 4'b0010;
   localparam logic [3:0] C_XOR  = 4'b0011;
   localparam logic [3:0] C_SUB  = 4'b0110;
   localparam logic [3:0] C_SLT  = 4'b0111;
   localparam logic [3:0] C_SLTU = 4'b1000;
   localparam logic [3:0] C_MUL  = 4'b1001;
   localparam logic [3:0] C_NOR  = 4'b1100;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [CW-1:0]    cnt;
   logic [3:0]       dec_ctrl;
   logic [WIDTH-1:0] op_res;
   logic             accept;

   always_comb begin
      dec_ctrl = C_ADD;
      case (alu_op)
         2'b00: dec_ctrl = C_ADD;
         2'b01: dec_ctrl = C_SUB;
         2'b11: dec_ctrl = C_OR;
         default: begin
            case (funct)
               6'b100000: dec_ctrl = C_ADD;
               6'b100010: dec_ctrl = C_SUB;
               6'b100100: dec_ctrl = C_AND;
               6'b100101: dec_ctrl = C_OR;
               6'b100110: dec_ctrl = C_XOR;
               6'b100111: dec_ctrl = C_NOR;
               6'b101010: dec_ctrl = C_SLT;
               6'b101011: dec_ctrl = C_SLTU;
               6'b011000: dec_ctrl = (MUL_EN != 0) ? C_MUL : C_ADD;
               default:   dec_ctrl = C_ADD;
            endcase
         end
      endcase
   end

   always_comb begin
      op_res = a + b;
      case (dec_ctrl)
         C_SUB:  op_res = a - b;
         C_AND:  op_res = a & b;
         C_OR:   op_res = a | b;
         C_XOR:  op_res = a ^ b;
         C_NOR:  op_res = ~(a | b);
         C_SLT:  op_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
         C_SLTU: op_res = (a < b) ? WIDTH'(1) : '0;
         default: op_res = a + b;
      endcase
   end

   // DONE can take a new op in the same cycle its result is consumed.
   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign zero      = (result == '0);
   assign acc_next  = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         result   <= '0;
         alu_ctrl <= C_ADD;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
      end else begin
         if (accept) begin
            alu_ctrl <= dec_ctrl;
            if (dec_ctrl == C_MUL) begin
               mcand  <= a;
               mplier <= b;
               acc    <= '0;
               cnt    <= '0;
               state  <= MUL;
            end else begin
               result <= op_res;
               state  <= DONE;
            end
         end else begin
            case (state)
               MUL: begin
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
                  // The last iteration's partial product goes straight to result.
                  if (cnt == CW'(WIDTH - 1)) begin
                     result <= acc_next;
                     state  <= DONE;
                  end
               end
               DONE: begin
                  if (out_ready) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   alu_op;
   logic [5:0]   funct;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero;
   logic [3:0]   alu_ctrl;
   logic         busy;

   typedef struct packed {
      logic [W-1:0] res;
      logic [3:0]   ctrl;
   } exp_t;

   exp_t sb[$];
   int   stamps[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   alu_exec_unit #(.WIDTH(W), .MUL_EN(1)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct(funct), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .alu_ctrl(alu_ctrl), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every transfer pops the oldest expected result.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none", result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_result", result, e.res);
            chk("sb_zero", W'(zero), W'(e.res == '0));
            chk("sb_ctrl", W'(alu_ctrl), W'(e.ctrl));
         end
         stamps.push_back(cyc);
      end
   end

   // Drives an op (phase: just after posedge) and waits for acceptance.
   // Leaves in_valid high so back-to-back calls keep the pipe full.
   task automatic issue(input logic [1:0] op, input logic [5:0] f,
                        input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] er, input logic [3:0] ec,
                        output int waits);
      bit acc_ok = 0;
      exp_t e;
      in_valid = 1'b1; alu_op = op; funct = f; a = xa; b = xb;
      waits = 0;
      while (!acc_ok && waits < 200) begin
         @(negedge clk);
         if (in_ready) acc_ok = 1;
         @(posedge clk);
         if (acc_ok) begin
            e.res = er; e.ctrl = ec;
            sb.push_back(e);
         end
         #1;
         waits++;
      end
      if (!acc_ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=no_accept required=accept");
      end
   endtask

   task automatic idle_cycles(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge clk);
      chk({tag, "_busy"}, W'(busy), W'(0));
      chk({tag, "_out_valid"}, W'(out_valid), W'(0));
      chk({tag, "_result"}, result, '0);
      chk({tag, "_zero"}, W'(zero), W'(1));
      chk({tag, "_alu_ctrl"}, W'(alu_ctrl), W'(4'b0010));
      chk({tag, "_in_ready"}, W'(in_ready), W'(1));
   endtask

   initial begin
      int w;
      int tot;
      int k;
      int n;
      int ir_bad;
      int seen;

      reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0;
      a = '0; b = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_state("rst");
      @(posedge clk); #1;

      // sub via funct, slt/sltu, branch compare, or, default funct
      issue(2'b10, 6'b100010, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0110, w);
      idle_cycles(2);
      issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111, w);
      idle_cycles(1);
      issue(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1000, w);
      idle_cycles(1);
      issue(2'b01, 6'b000000, 32'd9, 32'd9, 32'd0, 4'b0110, w);
      idle_cycles(1);
      issue(2'b11, 6'b101010, 32'h10, 32'h01, 32'h11, 4'b0001, w);
      idle_cycles(1);
      issue(2'b10, 6'b111111, 32'd3, 32'd4, 32'd7, 4'b0010, w);
      idle_cycles(2);

      // multiply latency and in_ready low while busy
      issue(2'b10, 6'b011000, 32'd12345, 32'd678, 32'd8369910, 4'b1001, w);
      in_valid = 1'b1; alu_op = 2'b00; a = 32'd1; b = 32'd1;
      ir_bad = 0;
      k = 0;
      seen = 0;
      while (!seen && k < 60) begin
         @(negedge clk);
         k++;
         if (out_valid) seen = 1;
         else if (in_ready) ir_bad++;
      end
      in_valid = 1'b0;
      chk("mul_latency", W'(k), W'(33));
      chk("mul_in_ready_low", W'(ir_bad), W'(0));
      @(posedge clk); #1;
      idle_cycles(2);

      // back-to-back throughput
      tot = 0;
      issue(2'b00, 6'b000000, 32'd100, 32'd23, 32'd123, 4'b0010, w); tot += w;
      issue(2'b10, 6'b100100, 32'hF0F0, 32'h0FF0, 32'h00F0, 4'b0000, w); tot += w;
      issue(2'b10, 6'b100110, 32'hFF00, 32'h0F0F, 32'hF00F, 4'b0011, w); tot += w;
      issue(2'b10, 6'b100111, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b1100, w); tot += w;
      idle_cycles(3);
      chk("b2b_accept_cycles", W'(tot), W'(4));
      n = stamps.size();
      if (n >= 4) chk("b2b_out_span", W'(stamps[n-1] - stamps[n-4]), W'(3));
      else chk("b2b_out_count", W'(n), W'(4));

      // backpressure: result held, new op ignored until out_ready
      out_ready = 1'b0;
      issue(2'b10, 6'b100101, 32'hA0, 32'h0B, 32'hAB, 4'b0001, w);
      alu_op = 2'b01; funct = 6'b000000; a = 32'd10; b = 32'd3;
      ir_bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (!out_valid || result !== 32'hAB || alu_ctrl !== 4'b0001 || in_ready) ir_bad++;
         @(posedge clk); #1;
      end
      chk("bp_hold_cycles_bad", W'(ir_bad), W'(0));
      n = stamps.size();
      out_ready = 1'b1;
      issue(2'b01, 6'b000000, 32'd10, 32'd3, 32'd7, 4'b0110, w);
      chk("bp_release_wait", W'(w), W'(1));
      idle_cycles(3);
      chk("bp_transfers", W'(stamps.size() - n), W'(2));

      // reset mid-multiply aborts without an output
      issue(2'b10, 6'b011000, 32'd3, 32'd5, 32'd15, 4'b1001, w);
      idle_cycles(9);
      reset = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_state("abort");
      n = stamps.size();
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_output", W'(stamps.size() - n), W'(0));

      k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk("sb_drained", W'(sb.size()), W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
